// File: rtl/axi_defs.sv
// AXI4 encodings shared by the instruction- and data-side SRAM-to-AXI bridges.
package axi_defs;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY_E   = 2'b00,
    AXI_RESP_EXOKAY_E = 2'b01,
    AXI_RESP_SLVERR_E = 2'b10,
    AXI_RESP_DECERR_E = 2'b11
  } axi_resp_e;

  localparam logic [7:0] AXI_LEN_SINGLE    = 8'd0;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_LOCK_NORMAL   = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0000;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

  // Anything but OKAY (EXOKAY included) is reported as an error to the core.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/outst_tracker.sv
// Counts accepted-but-unreturned reads and how many returning beats belong to
// cancelled requests and must be swallowed.
module outst_tracker #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             cancel,
  output logic [CNT_W-1:0] outst_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  logic dec_ok;

  assign dec_ok = dec & (outst_cnt != ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt <= ZERO;
      drop_cnt  <= ZERO;
    end else begin
      case ({inc, dec_ok})
        2'b10:   outst_cnt <= outst_cnt + ONE;
        2'b01:   outst_cnt <= outst_cnt - ONE;
        default: outst_cnt <= outst_cnt;
      endcase
      // A beat arriving with the cancel is already gone, so it is not counted again.
      if (cancel)
        drop_cnt <= dec_ok ? outst_cnt - ONE : outst_cnt;
      else if (dec_ok && drop_cnt != ZERO)
        drop_cnt <= drop_cnt - ONE;
    end
  end

endmodule

// File: rtl/inst_sram_axi_bridge.sv
// Instruction fetch bridge: SRAM-like req/addr_ok/data_ok to single-beat AXI4 reads,
// with in-order outstanding reads and cancel-on-flush.
module inst_sram_axi_bridge
  import axi_defs::*;
#(
  parameter int         MAX_OUTST = 2,
  parameter logic [3:0] AXI_ID    = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  input  logic        inst_sram_cancel,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  logic             ar_pend;
  logic             ar_free;
  logic [CNT_W-1:0] outst_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             unused_r;

  // Single beats with a constant ID: rid and rlast carry no information here.
  assign unused_r = ^{rid, rlast};

  assign ar_free           = ~ar_pend | arready;
  assign inst_sram_addr_ok = ~rst & inst_sram_req & ~inst_sram_cancel & ar_free &
                             (outst_cnt < MAX_C);

  // AR register: decoupled from req so the AXI side stays stable after addr_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_pend <= 1'b0;
      araddr  <= '0;
    end else if (inst_sram_addr_ok) begin
      ar_pend <= 1'b1;
      araddr  <= inst_sram_addr;
    end else if (arready) begin
      ar_pend <= 1'b0;
    end
  end

  outst_tracker #(
    .CNT_W(CNT_W)
  ) u_outst_tracker (
    .clk      (clk),
    .rst      (rst),
    .inc      (inst_sram_addr_ok),
    .dec      (rvalid),
    .cancel   (inst_sram_cancel),
    .outst_cnt(outst_cnt),
    .drop_cnt (drop_cnt)
  );

  assign arvalid = ar_pend;
  assign arid    = AXI_ID;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_DEFAULT;
  assign arprot  = AXI_PROT_DEFAULT;
  assign rready  = ~rst;

  // Beats owed to cancelled fetches, and any beat in the cancel cycle, never reach IF.
  assign inst_sram_data_ok = ~rst & rvalid & ~inst_sram_cancel & (drop_cnt == '0);
  assign inst_sram_rdata   = rdata;
  assign inst_sram_err     = inst_sram_data_ok & resp_is_err(rresp);

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Randomised bench for inst_sram_axi_bridge with a queue-based fetch model and
// an in-order single-beat AXI read slave.
module tb_inst_sram_axi_bridge;

  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        cancel = 1'b0;
  logic        addr_ok, data_ok, err;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } ent_t;

  ent_t        fq[$];       // accepted fetches, oldest first
  logic [31:0] slave_q[$];  // addresses the AXI slave has taken, awaiting R
  bit          m_ar_pend = 1'b0;
  logic [31:0] m_ar_addr = '0;

  inst_sram_axi_bridge #(
    .MAX_OUTST(MAX_OUTST),
    .AXI_ID   (4'd0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_sram_req    (req),
    .inst_sram_addr   (addr),
    .inst_sram_cancel (cancel),
    .inst_sram_addr_ok(addr_ok),
    .inst_sram_data_ok(data_ok),
    .inst_sram_rdata  (sram_rdata),
    .inst_sram_err    (err),
    .arid             (arid),
    .araddr           (araddr),
    .arlen            (arlen),
    .arsize           (arsize),
    .arburst          (arburst),
    .arlock           (arlock),
    .arcache          (arcache),
    .arprot           (arprot),
    .arvalid          (arvalid),
    .arready          (arready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .rvalid           (rvalid),
    .rready           (rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1e800400;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rq, input logic [31:0] ad, input bit cn, input bit ary,
                      input bit rv_en, input logic [1:0] rs);
    ent_t hd;
    bit   exp_aok;
    bit   exp_dok;
    @(posedge clk); #1;
    rst     = 1'b0;
    req     = rq;
    addr    = ad;
    cancel  = cn;
    arready = ary;
    rvalid  = rv_en && (slave_q.size() != 0);
    rdata   = rvalid ? mem_word(slave_q[0]) : $urandom;
    rresp   = rs;
    #3;
    chk("rready", rready, 1);
    chk("arvalid", arvalid, m_ar_pend);
    chk("araddr", araddr, m_ar_addr);
    chk("ar_fixed", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
        {4'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
    exp_aok = rq && !cn && (!m_ar_pend || ary) && (fq.size() < MAX_OUTST);
    chk("addr_ok", addr_ok, exp_aok);
    exp_dok = 1'b0;
    if (rvalid) begin
      if (fq.size() == 0) begin
        chk("fq_underrun", 0, 1);
      end else begin
        hd = fq.pop_front();
        exp_dok = !cn && !hd.drop;
        if (exp_dok) begin
          chk("rdata", sram_rdata, mem_word(hd.addr));
          chk("err", err, rs != 2'b00);
        end
      end
      void'(slave_q.pop_front());
    end
    chk("data_ok", data_ok, exp_dok);
    if (!exp_dok) chk("err_idle", err, 0);
    if (cn) foreach (fq[i]) fq[i].drop = 1'b1;
    if (m_ar_pend && ary) begin
      slave_q.push_back(m_ar_addr);
      m_ar_pend = 1'b0;
    end
    if (exp_aok) begin
      fq.push_back('{ad, 1'b0});
      m_ar_pend = 1'b1;
      m_ar_addr = ad;
    end
  endtask

  task automatic rst_step(input bit rq, input bit rv);
    @(posedge clk); #1;
    rst     = 1'b1;
    req     = rq;
    addr    = $urandom;
    cancel  = 1'b0;
    arready = 1'($urandom);
    rvalid  = rv;
    rdata   = $urandom;
    rresp   = 2'b10;
    #3;
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_err", err, 0);
    fq.delete();
    slave_q.delete();
    m_ar_pend = 1'b0;
    m_ar_addr = '0;
  endtask

  task automatic drain();
    repeat (8) step(0, 32'h0, 0, 1, 1, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_step(0, 0);
    rst_step(1, 1);

    // single fetch with the reference word
    step(1, 32'h1c000000, 0, 1, 0, 2'b00);
    step(0, 32'h0, 0, 1, 0, 2'b00);
    step(0, 32'h0, 0, 1, 1, 2'b00);
    drain();

    // AR back-pressure
    step(1, 32'h1c000010, 0, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) step(1, 32'h1c000020 + 32'(4 * i), 0, 0, 0, 2'b00);
    step(1, 32'h1c000040, 0, 1, 0, 2'b00);
    drain();

    // outstanding limit with R stalled
    step(1, 32'h1c000080, 0, 1, 0, 2'b00);
    step(1, 32'h1c000084, 0, 1, 0, 2'b00);
    step(1, 32'h1c000088, 0, 1, 0, 2'b00);
    step(1, 32'h1c000088, 0, 1, 1, 2'b00);
    step(1, 32'h1c000088, 0, 1, 0, 2'b00);
    drain();

    // cancel with two outstanding, then a fresh fetch
    step(1, 32'h1c000000, 0, 1, 0, 2'b00);
    step(1, 32'h1c000004, 0, 1, 0, 2'b00);
    step(0, 32'h0, 0, 1, 0, 2'b00);
    step(0, 32'h0, 1, 1, 0, 2'b00);
    step(1, 32'h1c000100, 0, 1, 0, 2'b00);
    drain();

    // cancel coincident with a beat and a pending AR
    step(1, 32'h1c000200, 0, 1, 0, 2'b00);
    step(1, 32'h1c000204, 0, 1, 0, 2'b00);
    step(0, 32'h0, 1, 0, 1, 2'b00);
    step(0, 32'h0, 0, 1, 0, 2'b00);
    step(1, 32'h1c000208, 0, 1, 1, 2'b00);
    drain();

    // error response, then reset mid-stream
    step(1, 32'h1c000300, 0, 1, 0, 2'b00);
    step(0, 32'h0, 0, 1, 0, 2'b00);
    step(0, 32'h0, 0, 1, 1, 2'b10);
    step(1, 32'h1c000400, 0, 1, 0, 2'b00);
    step(1, 32'h1c000404, 0, 0, 0, 2'b00);
    rst_step(1, 1);
    step(0, 32'h0, 0, 1, 0, 2'b00);
    step(1, 32'h1c000500, 0, 1, 0, 2'b00);
    drain();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_step(1'($urandom), 1'($urandom));
      end else begin
        step($urandom_range(0, 3) != 0, $urandom & 32'hffff_fffc,
             $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
             1'($urandom),
             ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
